// File: rtl/cache_fill_sequencer.sv
// Cache miss sequencer: writes back a dirty victim, fetches the missing line beat by beat,
// then writes the assembled line into the victim way and strobes the replacement policy.
module cache_fill_sequencer #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 512,
  parameter int AHBW    = 64,
  parameter int PA_BITS = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Miss,
  input  logic [PA_BITS-1:0] MissAddr,
  input  logic [NUMWAYS-1:0] VictimWay,
  input  logic               VictimDirty,
  input  logic [PA_BITS-1:0] VictimAddr,
  input  logic [LINELEN-1:0] VictimLine,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAddr,
  output logic [AHBW-1:0]    BusWData,
  input  logic               BusAck,
  input  logic [AHBW-1:0]    BusRData,
  output logic [NUMWAYS-1:0] LineWrEn,
  output logic [LINELEN-1:0] FillLine,
  output logic               LRUWriteEn,
  output logic               MissDone
);

  localparam int BEATS     = LINELEN / AHBW;
  localparam int CNTW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEATBYTES = AHBW / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    FETCH     = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state_r;
  state_t              stateNext_s;
  logic [CNTW-1:0]     beatCnt_r;
  logic [PA_BITS-1:0]  missAddr_r;
  logic [PA_BITS-1:0]  victimAddr_r;
  logic [NUMWAYS-1:0]  victimWay_r;
  logic [LINELEN-1:0]  victimLine_r;
  logic [LINELEN-1:0]  lineBuf_r;
  logic                lastBeat_s;
  logic [PA_BITS-1:0]  beatOffset_s;

  // Lines never straddle the address space top, so a plain modulo add is enough.
  assign lastBeat_s   = (beatCnt_r == CNTW'(BEATS - 1));
  assign beatOffset_s = PA_BITS'(beatCnt_r) * PA_BITS'(BEATBYTES);
  assign FillLine     = lineBuf_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Miss latch, beat counter and fill buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      beatCnt_r    <= '0;
      lineBuf_r    <= '0;
      missAddr_r   <= '0;
      victimAddr_r <= '0;
      victimWay_r  <= '0;
      victimLine_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Miss) begin
            missAddr_r   <= MissAddr;
            victimAddr_r <= VictimAddr;
            victimWay_r  <= VictimWay;
            victimLine_r <= VictimLine;
            beatCnt_r    <= '0;
          end
        end
        WRITEBACK: begin
          if (BusAck) begin
            beatCnt_r <= lastBeat_s ? '0 : beatCnt_r + CNTW'(1);
          end
        end
        FETCH: begin
          if (BusAck) begin
            lineBuf_r[beatCnt_r*AHBW +: AHBW] <= BusRData;
            beatCnt_r <= lastBeat_s ? '0 : beatCnt_r + CNTW'(1);
          end
        end
        default: begin
          beatCnt_r <= beatCnt_r;
        end
      endcase
    end
  end

  // Next-state and Moore output decode from the registered state.
  always_comb begin
    stateNext_s = state_r;
    BusReq      = 1'b0;
    BusWrite    = 1'b0;
    BusAddr     = '0;
    BusWData    = '0;
    LineWrEn    = '0;
    LRUWriteEn  = 1'b0;
    MissDone    = 1'b0;
    case (state_r)
      IDLE: begin
        if (Miss) begin
          stateNext_s = VictimDirty ? WRITEBACK : FETCH;
        end else begin
          stateNext_s = IDLE;
        end
      end
      WRITEBACK: begin
        BusReq   = 1'b1;
        BusWrite = 1'b1;
        BusAddr  = victimAddr_r + beatOffset_s;
        BusWData = victimLine_r[beatCnt_r*AHBW +: AHBW];
        if (BusAck && lastBeat_s) begin
          stateNext_s = FETCH;
        end else begin
          stateNext_s = WRITEBACK;
        end
      end
      FETCH: begin
        BusReq  = 1'b1;
        BusAddr = missAddr_r + beatOffset_s;
        if (BusAck && lastBeat_s) begin
          stateNext_s = WRITE;
        end else begin
          stateNext_s = FETCH;
        end
      end
      WRITE: begin
        LineWrEn    = victimWay_r;
        LRUWriteEn  = 1'b1;
        stateNext_s = DONE;
      end
      DONE: begin
        MissDone    = 1'b1;
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

endmodule
